// File: rtl/nano5bit_prefetch_if.sv
// Bundle of the CPU instruction port (i_*) and the instruction memory port (m_*)
// seen by the nano5bit prefetch buffer.
interface nano5bit_prefetch_if #(
  parameter int WIDTHIA = 12,
  parameter int WIDTHID = 32
) ();
  logic [WIDTHIA-1:0] i_address;
  logic               i_read;
  logic [WIDTHID-1:0] i_readdata;
  logic               i_waitrequest;
  logic [WIDTHIA-1:0] m_address;
  logic               m_read;
  logic               m_waitrequest;
  logic [WIDTHID-1:0] m_readdata;
  logic               m_readdatavalid;

  // Prefetch buffer view: slave to the CPU, master to memory.
  modport slave (
    input  i_address, i_read, m_waitrequest, m_readdata, m_readdatavalid,
    output i_readdata, i_waitrequest, m_address, m_read
  );

  // Environment view: the CPU plus the instruction memory.
  modport master (
    output i_address, i_read, m_waitrequest, m_readdata, m_readdatavalid,
    input  i_readdata, i_waitrequest, m_address, m_read
  );
endinterface

// File: rtl/nano5bit_prefetch.sv
// Sequential instruction prefetch buffer for nano5bit. Streams up to DEPTH words
// ahead of the CPU, serves sequential fetches with zero wait states and flushes /
// restarts on any non-sequential fetch.
module nano5bit_prefetch #(
  parameter int WIDTHIA = 12,
  parameter int WIDTHID = 32,
  parameter int DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 areset_n,
  nano5bit_prefetch_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // IDLE holds off streaming after reset so the first CPU fetch always
  // flushes and starts the stream at its own address.
  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state_q, state_d;
  logic [WIDTHID-1:0] fifo [DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count, pend, drop;
  logic [CW:0]        occ;
  logic [WIDTHIA-1:0] head_addr, fetch_addr;
  logic               hit, miss, issue, accept, push, discard;

  // State register.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state: the stream starts with the first CPU fetch after reset.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && bus.i_read) state_d = STREAM;
  end

  // Hit / miss detection, issue gating and response classification.
  always_comb begin
    occ     = {1'b0, count} + {1'b0, pend};
    hit     = bus.i_read && (count != '0) && (bus.i_address == head_addr);
    miss    = bus.i_read && !hit &&
              !((state_q == STREAM) && (count == '0) && (bus.i_address == head_addr));
    issue   = (state_q == STREAM) && !miss && (occ < (CW+1)'(DEPTH));
    accept  = issue && !bus.m_waitrequest;
    discard = bus.m_readdatavalid && (drop != '0);
    push    = bus.m_readdatavalid && (drop == '0) && !miss;
  end

  assign bus.i_waitrequest = ~hit;
  assign bus.i_readdata    = fifo[rd_ptr];
  assign bus.m_address     = fetch_addr;
  assign bus.m_read        = issue;

  // Buffer, pointers, counters and addresses; a miss overrides everything else.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pend       <= '0;
      drop       <= '0;
      head_addr  <= '0;
      fetch_addr <= '0;
    end else if (miss) begin
      count      <= '0;
      rd_ptr     <= wr_ptr;
      head_addr  <= bus.i_address;
      fetch_addr <= bus.i_address;
      pend       <= pend - CW'(bus.m_readdatavalid);
      drop       <= pend - CW'(bus.m_readdatavalid);
    end else begin
      if (push) begin
        fifo[wr_ptr] <= bus.m_readdata;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (hit) begin
        rd_ptr    <= rd_ptr + PW'(1);
        head_addr <= head_addr + WIDTHIA'(1);
      end
      if (accept) fetch_addr <= fetch_addr + WIDTHIA'(1);
      if (discard) drop <= drop - CW'(1);
      case ({push, hit})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      case ({accept, bus.m_readdatavalid})
        2'b10:   pend <= pend + CW'(1);
        2'b01:   pend <= pend - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nano5bit_prefetch.sv
// Directed bench for nano5bit_prefetch: CPU fetch sequences against a fixed
// latency-2 pipelined instruction memory whose word at address a is {20'hC0DE0, a}.
module tb_nano5bit_prefetch;

  logic clock;
  logic areset_n;
  int   vectors;
  int   miscompares;

  nano5bit_prefetch_if #(.WIDTHIA(12), .WIDTHID(32)) bus ();

  nano5bit_prefetch #(.WIDTHIA(12), .WIDTHID(32), .DEPTH(4)) u_dut (
    .clock    (clock),
    .areset_n (areset_n),
    .bus      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memword(input logic [11:0] a);
    return {20'hC0DE0, a};
  endfunction

  // Memory model: two-stage pipeline, one response per accepted read, latency 2.
  logic        v1, v2;
  logic [11:0] a1, a2;
  always @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      v1 <= 1'b0; v2 <= 1'b0; a1 <= '0; a2 <= '0;
    end else begin
      v1 <= bus.m_read & ~bus.m_waitrequest;
      a1 <= bus.m_address;
      v2 <= v1;
      a2 <= a1;
    end
  end
  assign bus.m_readdatavalid = v2;
  assign bus.m_readdata      = memword(a2);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // CPU fetch: hold the request until served; waits = stalled cycles.
  task automatic fetch(input logic [11:0] a, output int waits, output logic [31:0] data);
    bus.i_read    = 1'b1;
    bus.i_address = a;
    waits = 0;
    data  = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (!bus.i_waitrequest) begin
        data = bus.i_readdata;
        break;
      end
      waits++;
      tick();
    end
    tick();
    bus.i_read = 1'b0;
  endtask

  task automatic test_reset();
    areset_n          = 1'b0;
    bus.i_read        = 1'b0;
    bus.i_address     = '0;
    bus.m_waitrequest = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++; if (bus.m_read !== 1'b0) begin miscompares++; $display("FAIL rst_m_read got=%0h want=0", bus.m_read); end
    vectors++; if (bus.m_address !== 12'h000) begin miscompares++; $display("FAIL rst_m_address got=%0h want=0", bus.m_address); end
    vectors++; if (bus.i_waitrequest !== 1'b1) begin miscompares++; $display("FAIL rst_i_waitrequest got=%0h want=1", bus.i_waitrequest); end
    vectors++; if (bus.i_readdata !== 32'h0) begin miscompares++; $display("FAIL rst_i_readdata got=%0h want=0", bus.i_readdata); end
    areset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      vectors++; if (bus.m_read !== 1'b0) begin miscompares++; $display("FAIL idle_m_read got=%0h want=0", bus.m_read); end
      vectors++; if (bus.i_waitrequest !== 1'b1) begin miscompares++; $display("FAIL idle_i_waitrequest got=%0h want=1", bus.i_waitrequest); end
      tick();
    end
  endtask

  task automatic test_sequential();
    int w;
    logic [31:0] d;
    bus.i_read    = 1'b1;
    bus.i_address = 12'h004;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      vectors++; if (bus.m_read !== (c != 0)) begin miscompares++; $display("FAIL seq_m_read c%0d got=%0h want=%0h", c, bus.m_read, (c != 0)); end
      if (c != 0) begin
        vectors++; if (bus.m_address !== 12'(3 + c)) begin miscompares++; $display("FAIL seq_m_address c%0d got=%0h want=%0h", c, bus.m_address, 12'(3 + c)); end
      end
      vectors++; if (bus.i_waitrequest !== (c < 4)) begin miscompares++; $display("FAIL seq_i_waitrequest c%0d got=%0h want=%0h", c, bus.i_waitrequest, (c < 4)); end
      if (c == 4) begin
        vectors++; if (bus.i_readdata !== memword(12'h004)) begin miscompares++; $display("FAIL seq_first_data got=%0h want=%0h", bus.i_readdata, memword(12'h004)); end
      end
      tick();
    end
    for (int k = 5; k < 8; k++) begin
      fetch(12'(k), w, d);
      vectors++; if (w !== 0) begin miscompares++; $display("FAIL seq_waits a=%0h got=%0d want=0", k, w); end
      vectors++; if (d !== memword(12'(k))) begin miscompares++; $display("FAIL seq_data a=%0h got=%0h want=%0h", k, d, memword(12'(k))); end
    end
  endtask

  task automatic test_full();
    int w;
    logic [31:0] d;
    repeat (6) tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      vectors++; if (bus.m_read !== 1'b0) begin miscompares++; $display("FAIL full_m_read c%0d got=%0h want=0", c, bus.m_read); end
      tick();
    end
    fetch(12'h008, w, d);
    vectors++; if (w !== 0) begin miscompares++; $display("FAIL full_pop_waits got=%0d want=0", w); end
    vectors++; if (d !== memword(12'h008)) begin miscompares++; $display("FAIL full_pop_data got=%0h want=%0h", d, memword(12'h008)); end
    @(negedge clock);
    vectors++; if (bus.m_read !== 1'b1) begin miscompares++; $display("FAIL full_reissue_m_read got=%0h want=1", bus.m_read); end
    vectors++; if (bus.m_address !== 12'h00C) begin miscompares++; $display("FAIL full_reissue_addr got=%0h want=c", bus.m_address); end
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      vectors++; if (bus.m_read !== 1'b0) begin miscompares++; $display("FAIL full_single_issue c%0d got=%0h want=0", c, bus.m_read); end
      tick();
    end
  endtask

  task automatic test_waitrequest();
    int w;
    logic [31:0] d;
    bus.i_read        = 1'b1;
    bus.i_address     = 12'h008;
    bus.m_waitrequest = 1'b1;
    @(negedge clock);
    vectors++; if (bus.m_read !== 1'b0) begin miscompares++; $display("FAIL wr_flush_m_read got=%0h want=0", bus.m_read); end
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      vectors++; if (bus.m_read !== 1'b1) begin miscompares++; $display("FAIL wr_held_m_read c%0d got=%0h want=1", c, bus.m_read); end
      vectors++; if (bus.m_address !== 12'h008) begin miscompares++; $display("FAIL wr_held_addr c%0d got=%0h want=8", c, bus.m_address); end
      tick();
      vectors++; if (u_dut.pend !== 3'd0) begin miscompares++; $display("FAIL wr_held_pend c%0d got=%0d want=0", c, u_dut.pend); end
    end
    bus.m_waitrequest = 1'b0;
    @(negedge clock);
    vectors++; if (bus.m_address !== 12'h008) begin miscompares++; $display("FAIL wr_accept_addr got=%0h want=8", bus.m_address); end
    tick();
    vectors++; if (u_dut.pend !== 3'd1) begin miscompares++; $display("FAIL wr_accept_pend got=%0d want=1", u_dut.pend); end
    @(negedge clock);
    vectors++; if (bus.m_address !== 12'h009) begin miscompares++; $display("FAIL wr_next_addr got=%0h want=9", bus.m_address); end
    tick();
    fetch(12'h008, w, d);
    vectors++; if (w !== 1) begin miscompares++; $display("FAIL wr_hit_waits got=%0d want=1", w); end
    vectors++; if (d !== memword(12'h008)) begin miscompares++; $display("FAIL wr_hit_data got=%0h want=%0h", d, memword(12'h008)); end
  endtask

  task automatic test_flush();
    int w;
    logic [31:0] d;
    bus.i_read = 1'b0;
    repeat (8) tick();
    bus.i_read    = 1'b1;
    bus.i_address = 12'h010;
    @(negedge clock);
    vectors++; if (bus.m_read !== 1'b0) begin miscompares++; $display("FAIL fl_start_m_read got=%0h want=0", bus.m_read); end
    tick();
    bus.i_read = 1'b0;
    repeat (4) tick();
    vectors++; if (u_dut.count !== 3'd2) begin miscompares++; $display("FAIL fl_pre_count got=%0d want=2", u_dut.count); end
    vectors++; if (u_dut.pend !== 3'd2) begin miscompares++; $display("FAIL fl_pre_pend got=%0d want=2", u_dut.pend); end
    bus.i_read    = 1'b1;
    bus.i_address = 12'h200;
    @(negedge clock);
    vectors++; if (bus.m_read !== 1'b0) begin miscompares++; $display("FAIL fl_jump_m_read got=%0h want=0", bus.m_read); end
    vectors++; if (bus.i_waitrequest !== 1'b1) begin miscompares++; $display("FAIL fl_jump_waitreq got=%0h want=1", bus.i_waitrequest); end
    tick();
    vectors++; if (u_dut.pend !== 3'd1) begin miscompares++; $display("FAIL fl_post_pend got=%0d want=1", u_dut.pend); end
    vectors++; if (u_dut.drop !== 3'd1) begin miscompares++; $display("FAIL fl_post_drop got=%0d want=1", u_dut.drop); end
    fetch(12'h200, w, d);
    vectors++; if (w !== 3) begin miscompares++; $display("FAIL fl_hit_waits got=%0d want=3", w); end
    vectors++; if (d !== memword(12'h200)) begin miscompares++; $display("FAIL fl_hit_data got=%0h want=%0h", d, memword(12'h200)); end
    fetch(12'h201, w, d);
    vectors++; if (w !== 0) begin miscompares++; $display("FAIL fl_next_waits got=%0d want=0", w); end
    vectors++; if (d !== memword(12'h201)) begin miscompares++; $display("FAIL fl_next_data got=%0h want=%0h", d, memword(12'h201)); end
  endtask

  task automatic test_miss_with_response();
    int w;
    logic [31:0] d;
    repeat (8) tick();
    fetch(12'h202, w, d);
    vectors++; if (d !== memword(12'h202)) begin miscompares++; $display("FAIL mr_pop_data got=%0h want=%0h", d, memword(12'h202)); end
    repeat (2) tick();
    vectors++; if (u_dut.pend !== 3'd1) begin miscompares++; $display("FAIL mr_pre_pend got=%0d want=1", u_dut.pend); end
    vectors++; if (u_dut.drop !== 3'd0) begin miscompares++; $display("FAIL mr_pre_drop got=%0d want=0", u_dut.drop); end
    bus.i_read    = 1'b1;
    bus.i_address = 12'h300;
    @(negedge clock);
    vectors++; if (bus.m_read !== 1'b0) begin miscompares++; $display("FAIL mr_flush_m_read got=%0h want=0", bus.m_read); end
    tick();
    vectors++; if (u_dut.pend !== 3'd0) begin miscompares++; $display("FAIL mr_post_pend got=%0d want=0", u_dut.pend); end
    vectors++; if (u_dut.drop !== 3'd0) begin miscompares++; $display("FAIL mr_post_drop got=%0d want=0", u_dut.drop); end
    vectors++; if (u_dut.count !== 3'd0) begin miscompares++; $display("FAIL mr_post_count got=%0d want=0", u_dut.count); end
    @(negedge clock);
    vectors++; if (bus.i_waitrequest !== 1'b1) begin miscompares++; $display("FAIL mr_no_stale_hit got=%0h want=1", bus.i_waitrequest); end
    vectors++; if (bus.m_address !== 12'h300) begin miscompares++; $display("FAIL mr_issue_addr got=%0h want=300", bus.m_address); end
    tick();
    fetch(12'h300, w, d);
    vectors++; if (w !== 2) begin miscompares++; $display("FAIL mr_hit_waits got=%0d want=2", w); end
    vectors++; if (d !== memword(12'h300)) begin miscompares++; $display("FAIL mr_hit_data got=%0h want=%0h", d, memword(12'h300)); end
  endtask

  task automatic test_wrap();
    int w;
    logic [31:0] d;
    logic [11:0] a;
    fetch(12'hFFE, w, d);
    vectors++; if (w !== 4) begin miscompares++; $display("FAIL wrap_miss_waits got=%0d want=4", w); end
    vectors++; if (d !== memword(12'hFFE)) begin miscompares++; $display("FAIL wrap_first_data got=%0h want=%0h", d, memword(12'hFFE)); end
    a = 12'hFFF;
    for (int k = 0; k < 3; k++) begin
      fetch(a, w, d);
      vectors++; if (w !== 0) begin miscompares++; $display("FAIL wrap_waits a=%0h got=%0d want=0", a, w); end
      vectors++; if (d !== memword(a)) begin miscompares++; $display("FAIL wrap_data a=%0h got=%0h want=%0h", a, d, memword(a)); end
      a = a + 12'h001;
    end
  endtask

  task automatic test_reset_midstream();
    int w;
    logic [31:0] d;
    tick();
    areset_n = 1'b0;
    #2;
    vectors++; if (bus.m_read !== 1'b0) begin miscompares++; $display("FAIL mrst_m_read got=%0h want=0", bus.m_read); end
    vectors++; if (bus.m_address !== 12'h000) begin miscompares++; $display("FAIL mrst_m_address got=%0h want=0", bus.m_address); end
    vectors++; if (bus.i_waitrequest !== 1'b1) begin miscompares++; $display("FAIL mrst_i_waitrequest got=%0h want=1", bus.i_waitrequest); end
    vectors++; if (bus.i_readdata !== 32'h0) begin miscompares++; $display("FAIL mrst_i_readdata got=%0h want=0", bus.i_readdata); end
    tick();
    areset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      vectors++; if (bus.m_read !== 1'b0) begin miscompares++; $display("FAIL mrst_idle_m_read c%0d got=%0h want=0", c, bus.m_read); end
      tick();
    end
    fetch(12'h040, w, d);
    vectors++; if (w !== 4) begin miscompares++; $display("FAIL mrst_restart_waits got=%0d want=4", w); end
    vectors++; if (d !== memword(12'h040)) begin miscompares++; $display("FAIL mrst_restart_data got=%0h want=%0h", d, memword(12'h040)); end
    fetch(12'h041, w, d);
    vectors++; if (w !== 0) begin miscompares++; $display("FAIL mrst_next_waits got=%0d want=0", w); end
    vectors++; if (d !== memword(12'h041)) begin miscompares++; $display("FAIL mrst_next_data got=%0h want=%0h", d, memword(12'h041)); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_sequential();
    test_full();
    test_waitrequest();
    test_flush();
    test_miss_with_response();
    test_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

endmodule
